// File: rtl/tia_hsync_pkg.sv
// Shared definitions for the TIA horizontal sync counter.
//   - HCOUNT_W / HPHASE_W: widths of the polynomial step counter and sub-step phase.
//   - hdec_t: registered horizontal decode flags.
//   - lfsr6_next(s): one step of the 6-bit XNOR polynomial counter. The all-ones
//     lockup state is steered back to 000000.
//   - lfsr_at(k): counter value k steps after 000000. It is used to build the
//     decode constants at elaboration time.
package tia_hsync_pkg;

  localparam int HCOUNT_W = 6;
  localparam int HPHASE_W = 2;

  typedef struct packed {
    logic hsync;
    logic hblank;
    logic cb;
    logic line_start;
  } hdec_t;

  function automatic logic [HCOUNT_W-1:0] lfsr6_next(input logic [HCOUNT_W-1:0] s);
    logic [HCOUNT_W-1:0] n;
    // XNOR feedback can never leave all-ones, so that state is forced out.
    if (s == 6'b111111) begin
      n = 6'b000000;
    end else begin
      n = {s[4:0], ~(s[5] ^ s[4])};
    end
    return n;
  endfunction

  function automatic logic [HCOUNT_W-1:0] lfsr_at(input int k);
    logic [HCOUNT_W-1:0] s;
    s = '0;
    for (int i = 0; i < k; i++) begin
      s = lfsr6_next(s);
    end
    return s;
  endfunction

endpackage

// File: rtl/tia_lfsr6.sv
// 6-bit XNOR polynomial counter.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset, clears the counter to 000000
//   adv_i  : advance the counter by one polynomial step
//   clr_i  : synchronous clear to 000000 (overrides adv_i)
//   q_o    : current counter state
module tia_lfsr6
  import tia_hsync_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                adv_i,
  input  logic                clr_i,
  output logic [HCOUNT_W-1:0] q_o
);

  logic [HCOUNT_W-1:0] state_q;
  logic [HCOUNT_W-1:0] state_d;

  always_comb begin
    state_d = state_q;
    if (clr_i) begin
      state_d = '0;
    end else if (adv_i) begin
      state_d = lfsr6_next(state_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign q_o = state_q;

endmodule

// File: rtl/tia_horizontal_sync_counter.sv
// Horizontal timing generator. The colour clock is divided by four (hphase)
// into 57 polynomial steps (hcount), which gives 228 colour clocks per line.
// Decode outputs are registered, and each one changes on the edge where hcount
// enters its decoded step.
//   clk          : colour clock
//   reset_n      : asynchronous active-low reset
//   rsyn_gated   : RSYNC strobe. When high, the line restarts at step 0 on the next edge.
//   hmove        : HMOVE strobe. It sets the HMOVE latch.
//   hcount       : polynomial step counter state
//   hphase       : sub-step phase, 0..3
//   hsync        : horizontal sync
//   hblank       : horizontal blank. It is extended to LRHB_IDX when HMOVE is latched.
//   cb           : colour burst window
//   line_start   : high for the cycle after entry to step 0
//   hmove_active : HMOVE latch state
module tia_horizontal_sync_counter
  import tia_hsync_pkg::*;
#(
  parameter int SHS_IDX  = 4,
  parameter int RHS_IDX  = 8,
  parameter int RCB_IDX  = 12,
  parameter int RHB_IDX  = 16,
  parameter int LRHB_IDX = 18,
  parameter int END_IDX  = 56
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                rsyn_gated,
  input  logic                hmove,
  output logic [HCOUNT_W-1:0] hcount,
  output logic [HPHASE_W-1:0] hphase,
  output logic                hsync,
  output logic                hblank,
  output logic                cb,
  output logic                line_start,
  output logic                hmove_active
);

  localparam logic [HCOUNT_W-1:0] SHS_VAL  = lfsr_at(SHS_IDX);
  localparam logic [HCOUNT_W-1:0] RHS_VAL  = lfsr_at(RHS_IDX);
  localparam logic [HCOUNT_W-1:0] RCB_VAL  = lfsr_at(RCB_IDX);
  localparam logic [HCOUNT_W-1:0] RHB_VAL  = lfsr_at(RHB_IDX);
  localparam logic [HCOUNT_W-1:0] LRHB_VAL = lfsr_at(LRHB_IDX);
  localparam logic [HCOUNT_W-1:0] END_VAL  = lfsr_at(END_IDX);

  logic [HPHASE_W-1:0] phase_q, phase_d;
  logic [HCOUNT_W-1:0] hcount_q;
  logic [HCOUNT_W-1:0] step_next;   // step value the counter would enter without RSYNC
  logic                advance;
  logic                at_end;
  logic                step0_entry;  // natural line wrap into step 0, ignoring RSYNC
  hdec_t               dec_q, dec_d;
  logic                hmove_q, hmove_d;

  assign advance     = (phase_q == 2'd3);
  assign at_end      = (hcount_q == END_VAL);
  assign step_next   = at_end ? '0 : lfsr6_next(hcount_q);
  assign step0_entry = advance && (step_next == '0);

  tia_lfsr6 u_lfsr (
    .clk   (clk),
    .rst_n (reset_n),
    .adv_i (advance),
    .clr_i (rsyn_gated | (advance & at_end)),
    .q_o   (hcount_q)
  );

  always_comb begin
    phase_d            = phase_q + 2'd1;
    dec_d              = dec_q;
    dec_d.line_start   = 1'b0;
    if (rsyn_gated) begin
      phase_d          = '0;
      dec_d.hsync      = 1'b0;
      dec_d.hblank     = 1'b1;
      dec_d.cb         = 1'b0;
      dec_d.line_start = 1'b1;
    end else if (advance) begin
      if (step_next == SHS_VAL) dec_d.hsync = 1'b1;
      if (step_next == RHS_VAL) begin
        dec_d.hsync = 1'b0;
        dec_d.cb    = 1'b1;
      end
      if (step_next == RCB_VAL) dec_d.cb = 1'b0;
      // The latch value from before this edge decides whether blanking is extended.
      if ((step_next == RHB_VAL) && !hmove_q) dec_d.hblank = 1'b0;
      if (step_next == LRHB_VAL) dec_d.hblank = 1'b0;
      if (step_next == '0) begin
        dec_d.hblank     = 1'b1;
        dec_d.line_start = 1'b1;
      end
    end
  end

  // When a new HMOVE arrives on the same edge as the wrap, the set takes priority,
  // so the move applies to the new line.
  always_comb begin
    hmove_d = hmove_q;
    if (hmove) begin
      hmove_d = 1'b1;
    end else if (step0_entry) begin
      hmove_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= '0;
      dec_q   <= '{hsync: 1'b0, hblank: 1'b1, cb: 1'b0, line_start: 1'b0};
      hmove_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      dec_q   <= dec_d;
      hmove_q <= hmove_d;
    end
  end

  assign hcount       = hcount_q;
  assign hphase       = phase_q;
  assign hsync        = dec_q.hsync;
  assign hblank       = dec_q.hblank;
  assign cb           = dec_q.cb;
  assign line_start   = dec_q.line_start;
  assign hmove_active = hmove_q;

endmodule

// File: tb/tb_tia_horizontal_sync_counter.sv
module tb_tia_horizontal_sync_counter;

  localparam int SHS = 4, RHS = 8, RCB = 12, RHB = 16, LRHB = 18, ENDI = 56;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rsyn_gated = 1'b0;
  logic       hmove = 1'b0;
  logic [5:0] hcount;
  logic [1:0] hphase;
  logic       hsync, hblank, cb, line_start, hmove_active;

  always #5 clk = ~clk;

  tia_horizontal_sync_counter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rsyn_gated   (rsyn_gated),
    .hmove        (hmove),
    .hcount       (hcount),
    .hphase       (hphase),
    .hsync        (hsync),
    .hblank       (hblank),
    .cb           (cb),
    .line_start   (line_start),
    .hmove_active (hmove_active)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  // ---------------- counters / checker ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model (step-index based) ----------------
  logic [5:0] tab[57];
  int  m_k, m_ph;
  bit  m_latch, m_ext, m_ls;

  task automatic build_tab();
    logic [5:0] s;
    s = 6'b000000;
    for (int i = 0; i < 57; i++) begin
      tab[i] = s;
      s = {s[4:0], ~(s[5] ^ s[4])};
    end
  endtask

  task automatic model_reset();
    m_k = 0; m_ph = 0; m_latch = 0; m_ext = 0; m_ls = 0;
  endtask

  task automatic model_step(input bit rs, input bit hm);
    bit nat0, old_latch;
    nat0      = (m_ph == 3) && (m_k == ENDI);
    old_latch = m_latch;
    m_latch   = hm ? 1'b1 : (nat0 ? 1'b0 : m_latch);
    if (rs) begin
      m_k = 0; m_ph = 0; m_ls = 1; m_ext = 0;
    end else begin
      m_ls = 0;
      if (m_ph == 3) begin
        m_k = (m_k == ENDI) ? 0 : m_k + 1;
        if (m_k == RHB) m_ext = old_latch;
        if (m_k == 0) begin
          m_ext = 0;
          m_ls  = 1;
        end
      end
      m_ph = (m_ph + 1) % 4;
    end
  endtask

  function automatic logic [12:0] model_out();
    logic e_hs, e_hb, e_cb;
    e_hs = (m_k >= SHS) && (m_k < RHS);
    e_cb = (m_k >= RHS) && (m_k < RCB);
    e_hb = (m_k < RHB) || ((m_k < LRHB) && m_ext);
    return {tab[m_k], 2'(m_ph), e_hs, e_hb, e_cb, m_ls, m_latch};
  endfunction

  // ---------------- scoreboard / driver ----------------
  logic [12:0] exp_q[$];

  task automatic tick(input bit rs, input bit hm);
    logic [12:0] exp_v, got;
    rsyn_gated = rs;
    hmove      = hm;
    model_step(rs, hm);
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    cyc++;
    got = {hcount, hphase, hsync, hblank, cb, line_start, hmove_active};
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      exp_v = exp_q.pop_front();
      check("scoreboard", 32'(got), 32'(exp_v));
    end
    rsyn_gated = 1'b0;
    hmove      = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    rsyn_gated = 1'b0;
    hmove      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    exp_q.delete();
    cyc = 0;
  endtask

  // ---------------- first-line vector table ----------------
  typedef struct {
    int         clk_n;
    logic [5:0] hc;
    logic [1:0] ph;
    logic       hs, hb, cbv, ls;
  } chk_t;

  chk_t chk[10];

  initial begin
    int last_ls, n_ls;
    logic [5:0] v;

    chk[0] = '{0,   6'b000000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    chk[1] = '{15,  6'b000111, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0};
    chk[2] = '{16,  6'b001111, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    chk[3] = '{31,  6'b111101, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0};
    chk[4] = '{32,  6'b111011, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0};
    chk[5] = '{47,  6'b011110, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0};
    chk[6] = '{48,  6'b111100, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    chk[7] = '{63,  6'b100111, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0};
    chk[8] = '{64,  6'b001110, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    chk[9] = '{228, 6'b000000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1};

    build_tab();

    // 1) reset state, first line from the table, then a free run of 3 lines
    do_reset();
    check("reset_outputs", 32'({hcount, hphase, hsync, hblank, cb, line_start, hmove_active}),
          32'({6'b000000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
    last_ls = -1;
    n_ls    = 0;
    for (int c = 1; c <= 228 * 3 + 4; c++) begin
      tick(1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
        if (chk[i].clk_n == cyc)
          check("vector_table", 32'({hcount, hphase, hsync, hblank, cb, line_start}),
                32'({chk[i].hc, chk[i].ph, chk[i].hs, chk[i].hb, chk[i].cbv, chk[i].ls}));
      end
      if (hcount == 6'b111111) check("lockup_value", 32'(hcount), 32'd0);
      if (line_start) begin
        if (last_ls >= 0) check("line_period", 32'(cyc - last_ls), 32'd228);
        last_ls = cyc;
        n_ls++;
      end
    end
    check("line_start_count", 32'(n_ls), 32'd3);

    // 2) HMOVE pulse at clk 10 extends hblank on that line only
    do_reset();
    run(9);
    tick(1'b0, 1'b1);
    run(71 - cyc);
    check("hmove_hblank_71", 32'(hblank), 32'd1);
    tick(1'b0, 1'b0);
    check("hmove_hblank_72", 32'(hblank), 32'd0);
    run(228 - cyc);
    check("hmove_clear_at_wrap", 32'(hmove_active), 32'd0);
    run(228 + 63 - cyc);
    check("next_line_hblank_63", 32'(hblank), 32'd1);
    tick(1'b0, 1'b0);
    check("next_line_hblank_64", 32'(hblank), 32'd0);

    // 3) RSYNC single pulse at clk 100, then held for several cycles
    do_reset();
    run(99);
    tick(1'b1, 1'b0);
    check("rsync_state", 32'({hcount, hphase, hblank, line_start}),
          32'({6'b000000, 2'd0, 1'b1, 1'b1}));
    run(15);
    check("rsync_hsync_115", 32'(hsync), 32'd0);
    tick(1'b0, 1'b0);
    check("rsync_hsync_116", 32'(hsync), 32'd1);
    run(30);
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0);
      check("rsync_held_line_start", 32'(line_start), 32'd1);
    end
    run(240);

    // 4) HMOVE coincident with the step-0 entry edge
    do_reset();
    run(227);
    tick(1'b0, 1'b1);
    check("coincident_latch", 32'(hmove_active), 32'd1);
    check("coincident_line_start", 32'(line_start), 32'd1);
    run(228 + 71 - cyc);
    check("coincident_hblank_71", 32'(hblank), 32'd1);
    tick(1'b0, 1'b0);
    check("coincident_hblank_72", 32'(hblank), 32'd0);

    // 5) asynchronous reset mid-line while hsync is high
    do_reset();
    run(20);
    check("pre_reset_hsync", 32'(hsync), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_state", 32'({hcount, hphase, hsync, hblank, cb, line_start, hmove_active}),
          32'({6'b000000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    exp_q.delete();
    cyc = 0;
    run(300);

    // 6) random RSYNC / HMOVE traffic
    for (int i = 0; i < 600; i++) begin
      tick($urandom_range(0, 79) == 0, $urandom_range(0, 59) == 0);
    end
    run(230);
    v = hcount;
    check("no_lockup_final", 32'(v == 6'b111111), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
